// File: rtl/bpu_pkg.sv
// Shared BPU definitions: default sizes, PC step and the update-queue record layout.
package bpu_pkg;

  localparam int BPU_PC_W  = 32;
  localparam int BPU_DEPTH = 4;
  localparam int BPU_CNT_W = 8;

  // Sequential fetch step used for the not-taken redirect target.
  localparam int PC_INC = 4;

  // One pending BTB install at the default address width.
  typedef struct packed {
    logic                valid;
    logic [BPU_PC_W-1:0] pc;
    logic [BPU_PC_W-1:0] target;
  } btb_upd_entry_t;

endpackage

// File: rtl/btb_update_fifo.sv
// Coalescing FIFO storage for pending BTB installs: pointers with wrap bit,
// per-entry valid/PC/target, head read-out and a PC match vector.
module btb_update_fifo
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPU_DEPTH,
  parameter int PC_W  = BPU_PC_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             push_i,
  input  logic [PC_W-1:0]  push_pc_i,
  input  logic [PC_W-1:0]  push_target_i,
  input  logic             pop_i,
  input  logic             coal_i,
  input  logic [DEPTH-1:0] coal_sel_i,
  input  logic [PC_W-1:0]  coal_target_i,
  input  logic [PC_W-1:0]  match_pc_i,
  output logic [DEPTH-1:0] match_o,
  output logic [DEPTH-1:0] head_sel_o,
  output logic             head_valid_o,
  output logic [PC_W-1:0]  head_pc_o,
  output logic [PC_W-1:0]  head_target_o,
  output logic             full_o
);

  localparam int IDX_W = $clog2(DEPTH);

  logic [IDX_W:0]   wr_ptr_q, wr_ptr_d;
  logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0] valid_q;
  logic [PC_W-1:0]  pc_q     [DEPTH];
  logic [PC_W-1:0]  target_q [DEPTH];
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             empty;

  assign wr_idx = wr_ptr_q[IDX_W-1:0];
  assign rd_idx = rd_ptr_q[IDX_W-1:0];
  assign empty  = (wr_ptr_q == rd_ptr_q);
  assign full_o = (wr_idx == rd_idx) && (wr_ptr_q[IDX_W] != rd_ptr_q[IDX_W]);

  // Pointer advance: the wrap bit falls out of the extra MSB.
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{IDX_W{1'b0}}, push_i};
    rd_ptr_d = rd_ptr_q + {{IDX_W{1'b0}}, pop_i};
  end

  // Pointer registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage: pop clears the head, push fills the tail (a full-queue push
  // lands on the slot being popped, so push wins), coalesce rewrites a target.
  always_ff @(posedge CLK) begin
    if (RST) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (pop_i && head_sel_o[i]) valid_q[i] <= 1'b0;
        if (push_i && (wr_idx == IDX_W'(i))) begin
          valid_q[i]  <= 1'b1;
          pc_q[i]     <= push_pc_i;
          target_q[i] <= push_target_i;
        end else if (coal_i && coal_sel_i[i]) begin
          target_q[i] <= coal_target_i;
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign head_sel_o[gi] = (rd_idx == IDX_W'(gi));
      assign match_o[gi]    = valid_q[gi] && (pc_q[gi] == match_pc_i);
    end
  endgenerate

  assign head_valid_o  = ~empty;
  assign head_pc_o     = empty ? '0 : pc_q[rd_idx];
  assign head_target_o = empty ? '0 : target_q[rd_idx];

endmodule

// File: rtl/btb_update_queue.sv
// Branch-resolution side of the BPU: decides which EX outcomes need a BTB
// install, queues them (with coalescing), drains to the BTB write port, and
// registers the one-cycle fetch redirect on a BTB-level mispredict.
module btb_update_queue
  import bpu_pkg::*;
#(
  parameter int DEPTH = BPU_DEPTH,
  parameter int PC_W  = BPU_PC_W,
  parameter int CNT_W = BPU_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BPU__Stall,
  input  logic             EX_Valid,
  input  logic [PC_W-1:0]  EX_PC,
  input  logic [PC_W-1:0]  EX_Target,
  input  logic             EX_Taken,
  input  logic             EX_Pred_Hit,
  input  logic [PC_W-1:0]  EX_Pred_Target,
  output logic [PC_W-1:0]  BTB_Write_Addr,
  output logic [PC_W-1:0]  BTB_Write_Data,
  output logic             BTB_Write_En,
  output logic             Redirect_Valid,
  output logic [PC_W-1:0]  Redirect_PC,
  output logic             Queue_Full,
  output logic [CNT_W-1:0] Drop_Count
);

  logic             need_wr, mispred, pop, coal, push_req, push, drop;
  logic             head_valid, full;
  logic [DEPTH-1:0] match, head_sel, coal_sel;
  logic [PC_W-1:0]  next_pc;
  logic             redir_valid_q;
  logic [PC_W-1:0]  redir_pc_q;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Install/mispredict decode and queue admission for this cycle's EX outcome.
  always_comb begin
    need_wr  = EX_Valid && EX_Taken && (!EX_Pred_Hit || (EX_Pred_Target != EX_Target));
    mispred  = EX_Valid && (EX_Taken ? need_wr : EX_Pred_Hit);
    next_pc  = EX_Taken ? EX_Target : (EX_PC + PC_W'(PC_INC));
    pop      = head_valid && !BPU__Stall;
    // A match on the head being drained this cycle cannot absorb the update.
    coal_sel = match & ~(head_sel & {DEPTH{pop}});
    coal     = need_wr && (|coal_sel);
    push_req = need_wr && !coal;
    push     = push_req && (!full || pop);
    drop     = push_req && full && !pop;
  end

  btb_update_fifo #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_fifo (
    .CLK           (CLK),
    .RST           (RST),
    .push_i        (push),
    .push_pc_i     (EX_PC),
    .push_target_i (EX_Target),
    .pop_i         (pop),
    .coal_i        (coal),
    .coal_sel_i    (coal_sel),
    .coal_target_i (EX_Target),
    .match_pc_i    (EX_PC),
    .match_o       (match),
    .head_sel_o    (head_sel),
    .head_valid_o  (head_valid),
    .head_pc_o     (BTB_Write_Addr),
    .head_target_o (BTB_Write_Data),
    .full_o        (full)
  );

  // Saturating drop counter: holds at all-ones rather than wrapping.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
  end

  // Redirect and drop-count registers; reset also suppresses a same-cycle redirect.
  always_ff @(posedge CLK) begin
    if (RST) begin
      redir_valid_q <= 1'b0;
      redir_pc_q    <= '0;
      drop_cnt_q    <= '0;
    end else begin
      redir_valid_q <= mispred;
      redir_pc_q    <= next_pc;
      drop_cnt_q    <= drop_cnt_d;
    end
  end

  assign BTB_Write_En   = head_valid;
  assign Queue_Full     = full;
  assign Redirect_Valid = redir_valid_q;
  assign Redirect_PC    = redir_pc_q;
  assign Drop_Count     = drop_cnt_q;

endmodule

// File: tb/tb_btb_update_queue.sv
// Directed bench for btb_update_queue: a queue-based reference model checked
// every cycle, plus literal expectations at key points of the sequence.
module tb_btb_update_queue;

  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        BPU__Stall = 1'b0;
  logic        EX_Valid = 1'b0;
  logic [31:0] EX_PC = '0;
  logic [31:0] EX_Target = '0;
  logic        EX_Taken = 1'b0;
  logic        EX_Pred_Hit = 1'b0;
  logic [31:0] EX_Pred_Target = '0;
  logic [31:0] BTB_Write_Addr, BTB_Write_Data, Redirect_PC;
  logic        BTB_Write_En, Redirect_Valid, Queue_Full;
  logic [7:0]  Drop_Count;

  int n_chk  = 0;
  int n_pass = 0;

  btb_update_queue dut (
    .CLK            (CLK),
    .RST            (RST),
    .BPU__Stall     (BPU__Stall),
    .EX_Valid       (EX_Valid),
    .EX_PC          (EX_PC),
    .EX_Target      (EX_Target),
    .EX_Taken       (EX_Taken),
    .EX_Pred_Hit    (EX_Pred_Hit),
    .EX_Pred_Target (EX_Pred_Target),
    .BTB_Write_Addr (BTB_Write_Addr),
    .BTB_Write_Data (BTB_Write_Data),
    .BTB_Write_En   (BTB_Write_En),
    .Redirect_Valid (Redirect_Valid),
    .Redirect_PC    (Redirect_PC),
    .Queue_Full     (Queue_Full),
    .Drop_Count     (Drop_Count)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask

  // Reference model: ordered list of pending installs plus redirect/drop state.
  logic [31:0] mq_pc[$];
  logic [31:0] mq_tg[$];
  int          m_drop = 0;
  bit          m_rv = 1'b0;
  logic [31:0] m_rpc = '0;
  bit          m_live = 1'b0;

  always @(posedge CLK) begin : model
    int n;
    bit pop, need, coal;
    if (RST) begin
      mq_pc.delete();
      mq_tg.delete();
      m_drop = 0;
      m_rv   = 1'b0;
      m_rpc  = '0;
      m_live = 1'b1;
    end else if (m_live) begin
      n    = mq_pc.size();
      pop  = (n > 0) && !BPU__Stall;
      need = EX_Valid && EX_Taken && (!EX_Pred_Hit || EX_Pred_Target != EX_Target);
      coal = 1'b0;
      m_rv  = EX_Valid && (EX_Taken ? need : EX_Pred_Hit);
      m_rpc = EX_Taken ? EX_Target : EX_PC + 32'd4;
      if (need) begin
        for (int j = 0; j < n; j++) begin
          if (mq_pc[j] == EX_PC && !(j == 0 && pop)) begin
            mq_tg[j] = EX_Target;
            coal = 1'b1;
          end
        end
      end
      if (pop) begin
        void'(mq_pc.pop_front());
        void'(mq_tg.pop_front());
      end
      if (need && !coal) begin
        if (n < DEPTH || pop) begin
          mq_pc.push_back(EX_PC);
          mq_tg.push_back(EX_Target);
        end else if (m_drop < 255) begin
          m_drop++;
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge CLK) begin
    if (m_live) begin
      chk("m_wr_en",   32'(BTB_Write_En),   32'(mq_pc.size() != 0));
      chk("m_wr_addr", BTB_Write_Addr, (mq_pc.size() != 0) ? mq_pc[0] : 32'd0);
      chk("m_wr_data", BTB_Write_Data, (mq_tg.size() != 0) ? mq_tg[0] : 32'd0);
      chk("m_full",    32'(Queue_Full),     32'(mq_pc.size() == DEPTH));
      chk("m_drop",    32'(Drop_Count),     32'(m_drop));
      chk("m_rv",      32'(Redirect_Valid), 32'(m_rv));
      if (m_rv) chk("m_rpc", Redirect_PC, m_rpc);
    end
  end

  // One EX outcome presented for exactly one cycle; returns at the next negedge.
  task automatic ex(input logic [31:0] pc, input logic [31:0] tg, input logic tk,
                    input logic ph, input logic [31:0] pt);
    EX_Valid = 1'b1; EX_PC = pc; EX_Target = tg; EX_Taken = tk;
    EX_Pred_Hit = ph; EX_Pred_Target = pt;
    @(negedge CLK);
    EX_Valid = 1'b0;
    $display("ex pc=0x%08h tg=0x%08h tk=%0b hit=%0b -> rv=%0b rpc=0x%08h en=%0b head=0x%08h/0x%08h full=%0b drop=%0d",
             pc, tg, tk, ph, Redirect_Valid, Redirect_PC, BTB_Write_En, BTB_Write_Addr,
             BTB_Write_Data, Queue_Full, Drop_Count);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  initial begin
    // Reset
    idle(2);
    chk("rst_en",   32'(BTB_Write_En), 32'd0);
    chk("rst_drop", 32'(Drop_Count), 32'd0);
    chk("rst_rv",   32'(Redirect_Valid), 32'd0);
    chk("rst_addr", BTB_Write_Addr, 32'd0);
    RST = 1'b0;
    idle(1);

    // Cold miss
    ex(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    chk("cold_rv",   32'(Redirect_Valid), 32'd1);
    chk("cold_rpc",  Redirect_PC, 32'h200);
    chk("cold_en",   32'(BTB_Write_En), 32'd1);
    chk("cold_addr", BTB_Write_Addr, 32'h100);
    chk("cold_data", BTB_Write_Data, 32'h200);
    idle(1);
    chk("cold_pop_en", 32'(BTB_Write_En), 32'd0);
    chk("cold_rv_off", 32'(Redirect_Valid), 32'd0);

    // Correct predictions
    ex(32'h300, 32'h340, 1'b1, 1'b1, 32'h340);
    chk("hit_rv", 32'(Redirect_Valid), 32'd0);
    chk("hit_en", 32'(BTB_Write_En), 32'd0);
    ex(32'h80, 32'h999, 1'b0, 1'b1, 32'h999);
    chk("nt_rv",  32'(Redirect_Valid), 32'd1);
    chk("nt_rpc", Redirect_PC, 32'h84);
    chk("nt_en",  32'(BTB_Write_En), 32'd0);

    // Stall hold for five cycles
    BPU__Stall = 1'b1;
    ex(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    for (int k = 0; k < 5; k++) begin
      chk("hold_en",   32'(BTB_Write_En), 32'd1);
      chk("hold_addr", BTB_Write_Addr, 32'h100);
      if (k < 4) idle(1);
    end
    BPU__Stall = 1'b0;
    idle(1);
    chk("hold_pop_en", 32'(BTB_Write_En), 32'd0);

    // Coalesce under stall
    BPU__Stall = 1'b1;
    ex(32'h100, 32'h200, 1'b1, 1'b0, 32'h0);
    ex(32'h100, 32'h300, 1'b1, 1'b1, 32'h200);
    chk("coal_data", BTB_Write_Data, 32'h300);
    chk("coal_full", 32'(Queue_Full), 32'd0);
    BPU__Stall = 1'b0;
    idle(1);
    chk("coal_occ1", 32'(BTB_Write_En), 32'd0);

    // Overflow with DEPTH=4
    BPU__Stall = 1'b1;
    for (int k = 0; k < 6; k++) ex(32'h1000 + 32'(k * 16), 32'h5000 + 32'(k), 1'b1, 1'b0, 32'h0);
    chk("ovf_full", 32'(Queue_Full), 32'd1);
    chk("ovf_drop", 32'(Drop_Count), 32'd2);
    chk("ovf_head", BTB_Write_Addr, 32'h1000);
    BPU__Stall = 1'b0;
    ex(32'h2000, 32'h6000, 1'b1, 1'b0, 32'h0);
    chk("pp_full", 32'(Queue_Full), 32'd1);
    chk("pp_head", BTB_Write_Addr, 32'h1010);
    chk("pp_drop", 32'(Drop_Count), 32'd2);
    idle(4);
    chk("drain_en", 32'(BTB_Write_En), 32'd0);

    // Address wrap on not-taken redirect
    ex(32'hFFFF_FFFC, 32'h0, 1'b0, 1'b1, 32'h40);
    chk("wrap_rv",  32'(Redirect_Valid), 32'd1);
    chk("wrap_rpc", Redirect_PC, 32'h0);

    // Reset mid-operation with three entries queued and a mispredict in flight
    BPU__Stall = 1'b1;
    for (int k = 0; k < 3; k++) ex(32'h3000 + 32'(k * 4), 32'h7000, 1'b1, 1'b0, 32'h0);
    chk("pre_rst_en", 32'(BTB_Write_En), 32'd1);
    RST = 1'b1;
    ex(32'h4000, 32'h8000, 1'b1, 1'b0, 32'h0);
    RST = 1'b0;
    chk("mrst_en",   32'(BTB_Write_En), 32'd0);
    chk("mrst_drop", 32'(Drop_Count), 32'd0);
    chk("mrst_rv",   32'(Redirect_Valid), 32'd0);
    chk("mrst_full", 32'(Queue_Full), 32'd0);

    // Drop counter saturation
    for (int k = 0; k < 260; k++) ex(32'h10000 + 32'(k * 4), 32'h9000, 1'b1, 1'b0, 32'h0);
    chk("sat_drop", 32'(Drop_Count), 32'd255);
    ex(32'h20000, 32'h9000, 1'b1, 1'b0, 32'h0);
    chk("sat_hold", 32'(Drop_Count), 32'd255);
    chk("sat_full", 32'(Queue_Full), 32'd1);

    BPU__Stall = 1'b0;
    idle(5);
    chk("end_en", 32'(BTB_Write_En), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
